// File: rtl/mem_access_arbiter_pkg.sv
// rtl/mem_access_arbiter_pkg.sv - shared constants, read tag type and helpers for the memory arbiter
package mem_access_arbiter_pkg;

  localparam int WORD_W = 16;

  localparam logic OWN_CORE = 1'b0;
  localparam logic OWN_DBG  = 1'b1;

  localparam int MEM_LAT_MIN = 1;
  localparam int MEM_LAT_MAX = 3;
  localparam int SYNC_MIN    = 2;
  localparam int SYNC_MAX    = 3;

  typedef struct packed {
    logic valid;
    logic owner;
  } rd_tag_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/edge_sync_pulse.sv
// rtl/edge_sync_pulse.sv - multi-flop synchroniser plus rising-edge detect giving a one-clock pulse
module edge_sync_pulse #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic pulse
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], async_in};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign pulse = sync_q[STAGES-1] & ~prev_q;

endmodule

// File: rtl/mem_access_arbiter.sv
// rtl/mem_access_arbiter.sv - core/debug single-port memory arbiter with tagged read return
// Optional macro MEM_ARB_OVERRUN_EN adds o_dbgOverrun and o_dbgDropCnt.
module mem_access_arbiter
  import mem_access_arbiter_pkg::*;
#(
  parameter int MEM_LATENCY = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic              i_coreReq,
  input  logic [WORD_W-1:0] i_coreAddr,
  input  logic [WORD_W-1:0] i_coreWData,
  input  logic              i_coreWr,
  output logic              o_coreGnt,
  output logic              o_coreRValid,
  output logic [WORD_W-1:0] o_coreRData,
  input  logic              i_dbgEn,
  input  logic [WORD_W-1:0] i_dbgAddr,
  input  logic [WORD_W-1:0] i_dbgWData,
  input  logic              i_dbgWr,
  output logic [WORD_W-1:0] o_dbgRData,
  output logic              o_dbgBusy,
  input  logic              i_isPaused,
  output logic [WORD_W-1:0] o_memAddr,
  output logic [WORD_W-1:0] o_memWData,
  output logic              o_memWr,
  output logic              o_memEn,
  input  logic [WORD_W-1:0] i_memRData
`ifdef MEM_ARB_OVERRUN_EN
  ,
  output logic              o_dbgOverrun,
  output logic [7:0]        o_dbgDropCnt
`endif
);

  if (MEM_LATENCY < MEM_LAT_MIN || MEM_LATENCY > MEM_LAT_MAX) begin : g_bad_latency
    $error("MEM_LATENCY out of legal range");
  end
  if (SYNC_STAGES < SYNC_MIN || SYNC_STAGES > SYNC_MAX) begin : g_bad_sync
    $error("SYNC_STAGES out of legal range");
  end

  logic              dbg_edge;
  logic              dbg_pend;
  logic [WORD_W-1:0] hold_addr;
  logic [WORD_W-1:0] hold_wdata;
  logic              hold_wr;
  logic              mem_owner_q;
  logic              issue_dbg;
  logic              issue_core;
  logic              accept;
  logic              dbg_in_flight;
  rd_tag_t           iss_tag;
  rd_tag_t           tail_tag;
  rd_tag_t           tag_q [MEM_LATENCY];

  edge_sync_pulse #(
    .STAGES(SYNC_STAGES)
  ) u_dbg_sync (
    .clk     (i_clk),
    .rst_n   (i_rstn),
    .async_in(i_dbgEn),
    .pulse   (dbg_edge)
  );

  // Debug only takes the port while paused; a held core request just waits one slot.
  assign issue_dbg  = dbg_pend & i_isPaused;
  assign issue_core = i_coreReq & ~issue_dbg;
  assign o_coreGnt  = i_rstn & issue_core;
  assign o_dbgBusy  = dbg_pend | dbg_in_flight;
  assign accept     = dbg_edge & ~o_dbgBusy;
  assign tail_tag   = tag_q[MEM_LATENCY-1];

  always_comb begin
    iss_tag       = '0;
    iss_tag.valid = o_memEn & ~o_memWr;
    iss_tag.owner = mem_owner_q;
    dbg_in_flight = o_memEn & (mem_owner_q == OWN_DBG);
    for (int i = 0; i < MEM_LATENCY; i++) begin
      if (tag_q[i].valid && tag_q[i].owner == OWN_DBG) begin
        dbg_in_flight = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      dbg_pend     <= 1'b0;
      hold_addr    <= '0;
      hold_wdata   <= '0;
      hold_wr      <= 1'b0;
      o_memEn      <= 1'b0;
      o_memWr      <= 1'b0;
      o_memAddr    <= '0;
      o_memWData   <= '0;
      mem_owner_q  <= OWN_CORE;
      o_coreRValid <= 1'b0;
      o_coreRData  <= '0;
      o_dbgRData   <= '0;
      for (int i = 0; i < MEM_LATENCY; i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      if (accept) begin
        dbg_pend   <= 1'b1;
        hold_addr  <= i_dbgAddr;
        hold_wdata <= i_dbgWData;
        hold_wr    <= i_dbgWr;
      end else if (issue_dbg) begin
        dbg_pend <= 1'b0;
      end

      o_memEn <= issue_dbg | issue_core;
      if (issue_dbg) begin
        o_memAddr   <= hold_addr;
        o_memWData  <= hold_wdata;
        o_memWr     <= hold_wr;
        mem_owner_q <= OWN_DBG;
      end else if (issue_core) begin
        o_memAddr   <= i_coreAddr;
        o_memWData  <= i_coreWData;
        o_memWr     <= i_coreWr;
        mem_owner_q <= OWN_CORE;
      end else begin
        o_memWr <= 1'b0;
      end

      // Tag stage 0 lines up with the first cycle after o_memEn; the tail meets the read data.
      tag_q[0] <= iss_tag;
      for (int i = 1; i < MEM_LATENCY; i++) begin
        tag_q[i] <= tag_q[i-1];
      end

      o_coreRValid <= tail_tag.valid & (tail_tag.owner == OWN_CORE);
      if (tail_tag.valid && tail_tag.owner == OWN_CORE) begin
        o_coreRData <= i_memRData;
      end
      if (tail_tag.valid && tail_tag.owner == OWN_DBG) begin
        o_dbgRData <= i_memRData;
      end
    end
  end

`ifdef MEM_ARB_OVERRUN_EN
  logic drop;
  assign drop = dbg_edge & o_dbgBusy;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      o_dbgOverrun <= 1'b0;
      o_dbgDropCnt <= '0;
    end else if (drop) begin
      o_dbgOverrun <= 1'b1;
      o_dbgDropCnt <= sat_inc8(o_dbgDropCnt);
    end
  end
`endif

endmodule

// File: tb/tb_mem_access_arbiter.sv
// tb/tb_mem_access_arbiter.sv - directed bench driving latency-1 and latency-3 arbiters side by side
module tb_mem_access_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        core_req = 1'b0;
  logic [15:0] core_addr = '0;
  logic [15:0] core_wdata = '0;
  logic        core_wr = 1'b0;
  logic        dbg_en = 1'b0;
  logic [15:0] dbg_addr = '0;
  logic [15:0] dbg_wdata = '0;
  logic        dbg_wr = 1'b0;
  logic        paused = 1'b0;

  logic        core_gnt    [2];
  logic        core_rvalid [2];
  logic [15:0] core_rdata  [2];
  logic [15:0] dbg_rdata   [2];
  logic        dbg_busy    [2];
  logic [15:0] mem_addr    [2];
  logic [15:0] mem_wdata   [2];
  logic        mem_wr      [2];
  logic        mem_en      [2];
  logic [15:0] mem_rdata   [2];
`ifdef MEM_ARB_OVERRUN_EN
  logic        ovr  [2];
  logic [7:0]  dcnt [2];
`endif

  int n_err = 0;
  int n_chk = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_access_arbiter #(.MEM_LATENCY(1), .SYNC_STAGES(2)) u_l1 (
    .i_clk(clk), .i_rstn(rst_n),
    .i_coreReq(core_req), .i_coreAddr(core_addr), .i_coreWData(core_wdata), .i_coreWr(core_wr),
    .o_coreGnt(core_gnt[0]), .o_coreRValid(core_rvalid[0]), .o_coreRData(core_rdata[0]),
    .i_dbgEn(dbg_en), .i_dbgAddr(dbg_addr), .i_dbgWData(dbg_wdata), .i_dbgWr(dbg_wr),
    .o_dbgRData(dbg_rdata[0]), .o_dbgBusy(dbg_busy[0]), .i_isPaused(paused),
    .o_memAddr(mem_addr[0]), .o_memWData(mem_wdata[0]), .o_memWr(mem_wr[0]), .o_memEn(mem_en[0]),
    .i_memRData(mem_rdata[0])
`ifdef MEM_ARB_OVERRUN_EN
    , .o_dbgOverrun(ovr[0]), .o_dbgDropCnt(dcnt[0])
`endif
  );

  mem_access_arbiter #(.MEM_LATENCY(3), .SYNC_STAGES(2)) u_l3 (
    .i_clk(clk), .i_rstn(rst_n),
    .i_coreReq(core_req), .i_coreAddr(core_addr), .i_coreWData(core_wdata), .i_coreWr(core_wr),
    .o_coreGnt(core_gnt[1]), .o_coreRValid(core_rvalid[1]), .o_coreRData(core_rdata[1]),
    .i_dbgEn(dbg_en), .i_dbgAddr(dbg_addr), .i_dbgWData(dbg_wdata), .i_dbgWr(dbg_wr),
    .o_dbgRData(dbg_rdata[1]), .o_dbgBusy(dbg_busy[1]), .i_isPaused(paused),
    .o_memAddr(mem_addr[1]), .o_memWData(mem_wdata[1]), .o_memWr(mem_wr[1]), .o_memEn(mem_en[1]),
    .i_memRData(mem_rdata[1])
`ifdef MEM_ARB_OVERRUN_EN
    , .o_dbgOverrun(ovr[1]), .o_dbgDropCnt(dcnt[1])
`endif
  );

  // Untouched locations read back as pat(addr); written ones return the stored word.
  function automatic logic [15:0] pat(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'h3C3C;
  endfunction

  bit [15:0] mem0 [65536];
  bit        wv0  [65536];
  bit [15:0] mem1 [65536];
  bit        wv1  [65536];
  logic [15:0] rp0;
  logic [15:0] rp1 [3];

  always @(posedge clk) begin
    if (mem_en[0]) begin
      if (mem_wr[0]) begin
        mem0[mem_addr[0]] <= mem_wdata[0];
        wv0[mem_addr[0]]  <= 1'b1;
      end else begin
        rp0 <= wv0[mem_addr[0]] ? mem0[mem_addr[0]] : pat(mem_addr[0]);
      end
    end
    rp1[0] <= 16'h0;
    if (mem_en[1]) begin
      if (mem_wr[1]) begin
        mem1[mem_addr[1]] <= mem_wdata[1];
        wv1[mem_addr[1]]  <= 1'b1;
      end else begin
        rp1[0] <= wv1[mem_addr[1]] ? mem1[mem_addr[1]] : pat(mem_addr[1]);
      end
    end
    rp1[1] <= rp1[0];
    rp1[2] <= rp1[1];
  end

  assign mem_rdata[0] = rp0;
  assign mem_rdata[1] = rp1[2];

  logic [15:0] rv0_d[$];
  int          rv0_c[$];
  logic [15:0] rv1_d[$];
  int          rv1_c[$];
  logic [15:0] exp_d[$];

  always @(negedge clk) begin
    if (core_rvalid[0]) begin rv0_d.push_back(core_rdata[0]); rv0_c.push_back(cyc); end
    if (core_rvalid[1]) begin rv1_d.push_back(core_rdata[1]); rv1_c.push_back(cyc); end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    rv0_d.delete(); rv0_c.delete(); rv1_d.delete(); rv1_c.delete();
  endtask

  task automatic check_rv(input int inst, input int c_first);
    logic [15:0] gd[$];
    int          gc[$];
    if (inst == 0) begin gd = rv0_d; gc = rv0_c; end
    else begin gd = rv1_d; gc = rv1_c; end
    check_eq($sformatf("rvalid_count_i%0d", inst), gd.size(), exp_d.size());
    for (int k = 0; k < exp_d.size() && k < gd.size(); k++) begin
      check_eq($sformatf("rdata_i%0d_k%0d", inst, k), gd[k], exp_d[k]);
      if (c_first >= 0) check_eq($sformatf("rvalid_cycle_i%0d_k%0d", inst, k), gc[k], c_first + k);
    end
  endtask

  task automatic wait_idle(input string tag);
    int w = 0;
    while ((dbg_busy[0] || dbg_busy[1]) && w < 30) begin
      tick();
      w++;
    end
    check_eq(tag, {dbg_busy[0], dbg_busy[1]}, 2'b00);
  endtask

  task automatic check_reset_outs(input string tag);
    for (int i = 0; i < 2; i++) begin
      check_eq($sformatf("%s_ctl_i%0d", tag, i),
               {mem_en[i], mem_wr[i], core_gnt[i], core_rvalid[i], dbg_busy[i]}, 5'b0);
      check_eq($sformatf("%s_addr_i%0d", tag, i), {mem_addr[i], mem_wdata[i]}, 32'h0);
      check_eq($sformatf("%s_rdata_i%0d", tag, i), {core_rdata[i], dbg_rdata[i]}, 32'h0);
`ifdef MEM_ARB_OVERRUN_EN
      check_eq($sformatf("%s_ovr_i%0d", tag, i), {ovr[i], dcnt[i]}, 9'h0);
`endif
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int c0;
    int stalls;
    int w;
    logic seen;

    repeat (3) tick();
    check_reset_outs("reset");
    rst_n = 1'b1;
    tick();

    // Reset while a core read is in flight
    core_req = 1'b1; core_addr = 16'h0040; core_wr = 1'b0;
    #1;
    check_eq("midrst_gnt", {core_gnt[0], core_gnt[1]}, 2'b11);
    tick();
    core_req = 1'b0;
    #1;
    check_eq("midrst_issue", {mem_en[0], mem_addr[0]}, {1'b1, 16'h0040});
    rst_n = 1'b0;
    #1;
    check_reset_outs("midrst");
    tick(); tick();
    rst_n = 1'b1;
    clear_logs();
    repeat (8) tick();
    check_eq("midrst_no_rvalid", rv0_d.size() + rv1_d.size(), 0);

    // Back-to-back core reads
    clear_logs();
    c0 = 0;
    core_req = 1'b1;
    for (int k = 0; k < 3; k++) begin
      core_addr = 16'h0010 + 16'(k);
      #1;
      check_eq($sformatf("pipe_gnt_k%0d", k), {core_gnt[0], core_gnt[1]}, 2'b11);
      if (k == 0) c0 = cyc;
      tick();
    end
    core_req = 1'b0;
    #1;
    check_eq("pipe_last_addr", {mem_en[0], mem_addr[0]}, {1'b1, 16'h0012});
    repeat (10) tick();
    exp_d = '{pat(16'h0010), pat(16'h0011), pat(16'h0012)};
    check_rv(0, c0 + 3);
    check_rv(1, c0 + 5);

    // Debug read strobed while running, released by pause
    clear_logs();
    paused = 1'b0;
    dbg_addr = 16'h1234; dbg_wr = 1'b0; dbg_wdata = 16'h0;
    dbg_en = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      seen = seen | mem_en[0] | mem_en[1];
    end
    check_eq("run_busy", {dbg_busy[0], dbg_busy[1]}, 2'b11);
    check_eq("run_no_mem_en", seen, 1'b0);
    dbg_en = 1'b0;
    tick();
    paused = 1'b1;
    tick();
    check_eq("run_issue", {mem_en[0], mem_wr[0], mem_en[1], mem_wr[1]}, 4'b1010);
    check_eq("run_issue_addr", {mem_addr[0], mem_addr[1]}, {16'h1234, 16'h1234});
    wait_idle("run_busy_fall");
    check_eq("run_dbg_rdata0", dbg_rdata[0], pat(16'h1234));
    check_eq("run_dbg_rdata1", dbg_rdata[1], pat(16'h1234));
    check_eq("run_no_core_rvalid", rv0_d.size() + rv1_d.size(), 0);

    // Debug write and core read meet in the same cycle while paused
    clear_logs();
    dbg_addr = 16'h0002; dbg_wdata = 16'hBEEF; dbg_wr = 1'b1;
    dbg_en = 1'b1;
    tick(); tick(); tick();
    core_req = 1'b1; core_addr = 16'h0002; core_wr = 1'b0;
    #1;
    check_eq("sim_core_held", {core_gnt[0], core_gnt[1]}, 2'b00);
    check_eq("sim_busy", {dbg_busy[0], dbg_busy[1]}, 2'b11);
    tick();
    check_eq("sim_dbg_issue", {mem_en[0], mem_wr[0], mem_en[1], mem_wr[1]}, 4'b1111);
    check_eq("sim_dbg_addr_data", {mem_addr[0], mem_wdata[0]}, {16'h0002, 16'hBEEF});
    check_eq("sim_core_next", {core_gnt[0], core_gnt[1]}, 2'b11);
    c0 = cyc;
    tick();
    core_req = 1'b0;
    dbg_en = 1'b0;
    repeat (10) tick();
    check_eq("sim_mem_l1", mem0[2], 16'hBEEF);
    check_eq("sim_mem_l3", mem1[2], 16'hBEEF);
    exp_d = '{16'hBEEF};
    check_rv(0, c0 + 3);
    check_rv(1, c0 + 5);

    // Second strobe while the first is still pending is dropped
    paused = 1'b0;
    dbg_addr = 16'h0100; dbg_wr = 1'b0; dbg_wdata = 16'h0;
    dbg_en = 1'b1;
    repeat (5) tick();
    dbg_en = 1'b0;
    repeat (3) tick();
    dbg_addr = 16'h0200;
    dbg_en = 1'b1;
    repeat (5) tick();
    dbg_en = 1'b0;
    repeat (2) tick();
`ifdef MEM_ARB_OVERRUN_EN
    check_eq("ovr_flag", {ovr[0], ovr[1]}, 2'b11);
    check_eq("ovr_cnt", {dcnt[0], dcnt[1]}, {8'd1, 8'd1});
`endif
    paused = 1'b1;
    tick();
    check_eq("ovr_addr_kept", {mem_addr[0], mem_addr[1]}, {16'h0100, 16'h0100});
    wait_idle("ovr_busy_fall");
    check_eq("ovr_dbg_rdata", {dbg_rdata[0], dbg_rdata[1]}, {pat(16'h0100), pat(16'h0100)});

    // Interleaved core and debug reads while paused
    clear_logs();
    dbg_addr = 16'h0030; dbg_wr = 1'b0;
    dbg_en = 1'b1;
    stalls = 0;
    for (int k = 0; k < 4; k++) begin
      core_req = 1'b1; core_addr = 16'h0020 + 16'(k);
      #1;
      w = 0;
      while (!core_gnt[0] && w < 10) begin
        tick();
        #1;
        w++;
      end
      stalls += w;
      check_eq($sformatf("sweep_gnt_k%0d", k), {core_gnt[0], core_gnt[1]}, 2'b11);
      tick();
    end
    core_req = 1'b0;
    dbg_en = 1'b0;
    check_eq("sweep_stalls", stalls, 1);
    repeat (12) tick();
    exp_d = '{pat(16'h0020), pat(16'h0021), pat(16'h0022), pat(16'h0023)};
    check_rv(0, -1);
    check_rv(1, -1);
    check_eq("sweep_dbg_rdata", {dbg_rdata[0], dbg_rdata[1]}, {pat(16'h0030), pat(16'h0030)});
    check_eq("sweep_core_rdata_kept", {core_rdata[0], core_rdata[1]}, {pat(16'h0023), pat(16'h0023)});
    check_eq("sweep_idle", {dbg_busy[0], dbg_busy[1]}, 2'b00);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/mem_access_arbiter.md
Name: mem_access_arbiter

Overview:
- Shares the single-port runtime memory between the core load/store/fetch path and the JTAG debug memory-command path.
- Synchronises the TCK-domain debug strobe into the system clock domain and queues one debug access.
- Grants the debug path only while the uP is truly PAUSED.
- Tags in-flight reads and returns each result to its owner.

Parameters:
- MEM_LATENCY, 1, read-data latency of the memory in i_clk cycles (legal 1..3).
- SYNC_STAGES, 2, flop count of the debug-strobe synchroniser (legal 2..3).

Ports:
- i_clk  in  1  system clock; all state updates on the rising edge.
- i_rstn  in  1  asynchronous, active-low reset.
- i_coreReq  in  1  core access request (level; held until o_coreGnt).
- i_coreAddr  in  16  core address.
- i_coreWData  in  16  core write data.
- i_coreWr  in  1  1 = write, 0 = read.
- o_coreGnt  out  1  core access issued this cycle.
- o_coreRValid  out  1  core read data valid (one-cycle pulse).
- o_coreRData  out  16  core read data.
- i_dbgEn  in  1  TCK-domain debug memory strobe (asynchronous to i_clk).
- i_dbgAddr  in  16  debug address (quasi-static while the strobe is active).
- i_dbgWData  in  16  debug write data (quasi-static).
- i_dbgWr  in  1  debug read/write select (quasi-static).
- o_dbgRData  out  16  last debug read result; held until the next debug read completes.
- o_dbgBusy  out  1  debug access pending or in flight.
- i_isPaused  in  1  uP is in the PAUSED state.
- o_memAddr  out  16  memory address.
- o_memWData  out  16  memory write data.
- o_memWr  out  1  memory write enable (qualified by o_memEn).
- o_memEn  out  1  memory access strobe.
- i_memRData  in  16  memory read data, valid MEM_LATENCY cycles after o_memEn.

Behaviour:
- Reset (async, i_rstn = 0): all outputs 0, synchroniser cleared, pending and in-flight state cleared. In-flight reads are discarded; no o_coreRValid fires after reset.
- Debug capture:
  - i_dbgEn passes through SYNC_STAGES flops plus one edge-detect flop.
  - A synced rising edge sets dbgPend and captures i_dbgAddr, i_dbgWData and i_dbgWr into holding registers.
  - Latency from edge to capture is SYNC_STAGES+1 clocks.
- Arbiter states:
  - IDLE. Per cycle, at most one access is issued.
  - If dbgPend & i_isPaused: issue the debug access (o_memEn = 1 with the captured address, data and write select) and clear dbgPend.
  - Else if i_coreReq: issue the core access, with o_coreGnt = 1 in the same cycle.
  - Debug wins over a simultaneous core request while paused.
  - While not paused, dbgPend waits indefinitely; the core is never blocked.
- Memory outputs are registered.
  - o_memEn, o_memAddr, o_memWData and o_memWr are driven from flops loaded in the grant cycle, i.e. visible one cycle after the grant decision.
  - o_coreGnt is combinational in the decision cycle.
- Read tagging:
  - A shift register of depth MEM_LATENCY carries {valid, owner} per issued read. Writes push valid = 0.
  - At the tail, owner = core pulses o_coreRValid with o_coreRData = i_memRData.
  - Owner = debug loads o_dbgRData.
  - Back-to-back core reads are fully pipelined: one per cycle.
- o_dbgBusy = dbgPend | any in-flight debug read | debug write in its issue cycle.
- Overrun: a synced debug edge while o_dbgBusy = 1 is dropped. Holding registers are unchanged and dbgPend is unchanged.
- i_isPaused falling while dbgPend = 1: the request stays pending until the next pause.
- The uP is expected to stop issuing i_coreReq once paused. Any core request made while paused is granted only when dbgPend = 0.

Optional Feature:
- Macro: MEM_ARB_OVERRUN_EN.
- With the macro: adds output o_dbgOverrun (1 bit), a sticky flag set by a dropped debug edge and cleared only by reset. Also adds o_dbgDropCnt (8 bits), a saturating count of dropped edges (saturates at 8'hFF).
- Without the macro: neither port exists and dropped edges are silent.

Decomposition:
- Shared package holds:
  - Owner tag constants: OWN_CORE = 1'b0, OWN_DBG = 1'b1.
  - The 16-bit word width constant.
  - Legal ranges for MEM_LATENCY and SYNC_STAGES.
- One natural sub-module: edge_sync_pulse, covering the SYNC_STAGES synchroniser plus rising-edge detect and producing a one-clock pulse. It is reusable for other TCK-to-clk controls such as the pause trigger.

Test Plan:
- Reset mid read: core read of 0x0040 issued, i_rstn pulsed low before data returns -> no o_coreRValid; all outputs 0 during reset.
- Core pipelining: core reads 0x0010, 0x0011, 0x0012 on consecutive cycles with MEM_LATENCY = 1 -> o_coreGnt = 1 for 3 cycles; o_coreRValid on 3 consecutive cycles with matching data.
- Debug while running: i_isPaused = 0, debug read of 0x1234 strobed -> o_dbgBusy = 1, no o_memEn for debug. Raise i_isPaused -> access issued within 1 cycle; o_dbgRData = mem[0x1234]; o_dbgBusy falls.
- Simultaneous: i_isPaused = 1, dbgPend set (write 0xBEEF to 0x0002) and i_coreReq = 1 in the same cycle -> debug issued first with o_coreGnt = 0; core granted the next cycle; mem[0x0002] = 0xBEEF.
- Overrun: second i_dbgEn edge while the first is pending -> captured address unchanged. With MEM_ARB_OVERRUN_EN: o_dbgOverrun = 1, o_dbgDropCnt = 1.
- Latency sweep: MEM_LATENCY = 3, interleaved core/debug reads while paused -> each result routed to the correct owner; o_coreRData is never overwritten by a debug result.
